// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   // Width of a requester id; never narrower than one bit.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_owner, wrapping.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = tag_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   last_owner,
   output logic             found,
   output logic [IDW-1:0]   winner
);

   logic [N_REQ-1:0] rotated;

   // Rotate so last_owner+1 sits at bit 0, priority-encode the lowest bit, un-rotate.
   always_comb begin
      int start;
      int idx;
      int pos;
      start   = (int'(last_owner) >= N_REQ-1) ? 0 : int'(last_owner) + 1;
      rotated = '0;
      found   = 1'b0;
      pos     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = start + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         rotated[i] = req[idx];
      end
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rotated[i]) begin
            found = 1'b1;
            pos   = i;
         end
      end
      idx = start + pos;
      if (idx >= N_REQ) idx = idx - N_REQ;
      winner = IDW'(idx);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ requesters,
// granting bursts of up to BURST beats with zero-latency data forwarding.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N_REQ = 4,
   parameter  int BURST = 4,
   localparam int IDW   = tag_width(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   fifo_full,
   output logic                   fifo_write,
   output logic [WIDTH-1:0]       fifo_wdata,
   output logic [IDW-1:0]         fifo_wtag,
   output logic                   grant_valid,
   output logic [IDW-1:0]         grant_id
);

   localparam int CW = $clog2(BURST) + 1;

   arb_state_t      state, state_nxt;
   logic [IDW-1:0]  owner, owner_nxt;
   logic [IDW-1:0]  last_owner, last_owner_nxt;
   logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
   logic [IDW-1:0]  pick_base;
   logic [IDW-1:0]  winner;
   logic            found;
   logic            rel;

   // A releasing owner re-arbitrates from owner+1 in the same cycle, so one picker serves both.
   assign pick_base = (state == GRANT) ? owner : last_owner;

   rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req        (req_valid),
      .last_owner (pick_base),
      .found      (found),
      .winner     (winner)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      beat_cnt_nxt   = beat_cnt;
      rel            = 1'b0;
      req_ready      = '0;
      fifo_write     = 1'b0;
      fifo_wdata     = '0;
      fifo_wtag      = '0;
      grant_valid    = 1'b0;
      grant_id       = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = GRANT;
               owner_nxt    = winner;
               beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            grant_valid      = 1'b1;
            grant_id         = owner;
            req_ready[owner] = !fifo_full;
            fifo_write       = req_valid[owner] && !fifo_full;
            fifo_wdata       = req_data[int'(owner)*WIDTH +: WIDTH];
            fifo_wtag        = owner;
            // A full fifo freezes everything: no write, no count, grant held.
            if (!fifo_full) begin
               if (req_valid[owner]) begin
                  beat_cnt_nxt = beat_cnt + CW'(1);
                  rel          = req_last[owner] || (beat_cnt == CW'(BURST-1));
               end else begin
                  rel = 1'b1;
               end
               if (rel) begin
                  last_owner_nxt = owner;
                  beat_cnt_nxt   = '0;
                  if (found) begin
                     owner_nxt = winner;
                  end else begin
                     state_nxt = IDLE;
                     owner_nxt = '0;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDW'(N_REQ-1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter against a cycle-level reference model.
module tb_fifo_wr_arbiter;

   localparam int W     = 8;
   localparam int N     = 4;
   localparam int BURST = 4;
   localparam int IDW   = 2;
   localparam int OW    = 1 + IDW + N + 1 + W + IDW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_last  = '0;
   logic [N*W-1:0]   req_data  = '0;
   logic [N-1:0]     req_ready;
   logic             fifo_full = 1'b0;
   logic             fifo_write;
   logic [W-1:0]     fifo_wdata;
   logic [IDW-1:0]   fifo_wtag;
   logic             grant_valid;
   logic [IDW-1:0]   grant_id;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit m_gnt;
   int m_own, m_last, m_beats;
   int seq [N];
   logic [OW-1:0] exp_v;
   logic [OW-1:0] obs;

   fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .BURST(BURST)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_write  (fifo_write),
      .fifo_wdata  (fifo_wdata),
      .fifo_wtag   (fifo_wtag),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   assign obs = {grant_valid, grant_id, req_ready, fifo_write, fifo_wdata, fifo_wtag};

   function automatic logic [W-1:0] data_of(input int i);
      return W'((i + 1) * 16 + 1 + seq[i]);
   endfunction

   function automatic int pick(input int base, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(base + k) % N]) return (base + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_gnt = 0; m_own = 0; m_last = N - 1; m_beats = 0;
   endtask

   task automatic model_outputs();
      logic [N-1:0]   rdy;
      logic           wr;
      logic [W-1:0]   d;
      logic [IDW-1:0] id;
      rdy = '0;
      wr  = 1'b0;
      d   = '0;
      id  = '0;
      if (m_gnt) begin
         id  = IDW'(m_own);
         d   = data_of(m_own);
         if (!fifo_full) rdy[m_own] = 1'b1;
         wr  = req_valid[m_own] && !fifo_full;
      end
      exp_v = {m_gnt, id, rdy, wr, d, id};
   endtask

   task automatic model_update();
      int  w;
      bit  r;
      if (!m_gnt) begin
         w = pick(m_last, req_valid);
         if (w >= 0) begin m_gnt = 1; m_own = w; m_beats = 0; end
      end else if (!fifo_full) begin
         r = 0;
         if (req_valid[m_own]) begin
            seq[m_own]++;
            m_beats++;
            if (req_last[m_own] || m_beats == BURST) r = 1;
         end else begin
            r = 1;
         end
         if (r) begin
            m_last = m_own;
            w = pick(m_own, req_valid);
            if (w >= 0) begin m_own = w; m_beats = 0; end
            else begin m_gnt = 0; m_own = 0; end
         end
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
      req_valid = v;
      req_last  = l;
      fifo_full = f;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = data_of(i);
      #1;
      model_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) model_reset();
      else     model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) seq[i] = 0;
      drive('0, '0, 1'b0);
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         drive(N'($urandom), N'($urandom), 1'($urandom));
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_reset cycle %0d: got %h want %h", c, obs, exp_v);
         end
         advance();
      end
      do_reset();
   endtask

   task automatic test_single();
      logic [W-1:0] got [$];
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive((seq[0] < 3) ? N'(1) : N'(0), (seq[0] == 2) ? N'(1) : N'(0), 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_single cycle %0d: got %h want %h", c, obs, exp_v);
         end
         if (fifo_write) got.push_back(fifo_wdata);
         advance();
      end
      vectors++;
      if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h12 || got[2] !== 8'h13) begin
         miscompares++;
         $display("FAIL test_single data: got %0d beats, want 3 beats 11 12 13", got.size());
      end
   endtask

   task automatic test_all_valid();
      int tags [$];
      bit bad;
      do_reset();
      for (int c = 0; c < 21; c++) begin
         drive('1, '0, 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_all_valid cycle %0d: got %h want %h", c, obs, exp_v);
         end
         if (fifo_write) tags.push_back(int'(fifo_wtag));
         advance();
      end
      bad = (tags.size() != 20);
      for (int i = 0; i < tags.size() && i < 20; i++) if (tags[i] != (i / 4) % 4) bad = 1;
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL test_all_valid order: got %0d writes, want 20 in tag order 0,1,2,3,0", tags.size());
      end
   endtask

   task automatic test_full_hold();
      logic [N-1:0] v;
      logic         f;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         f = (c >= 3 && c <= 7);
         v = f ? (N'($urandom) | N'(4)) : N'(4);
         if (f && $urandom_range(0, 1) == 0) v[2] = 1'b0;
         drive(v, '0, f);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_full_hold cycle %0d: got %h want %h", c, obs, exp_v);
         end
         advance();
      end
   endtask

   task automatic test_drop_valid();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive((c < 3) ? N'(2) : N'(8), '0, 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_drop_valid cycle %0d: got %h want %h", c, obs, exp_v);
         end
         advance();
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(N'(2), '0, 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_mid_reset cycle %0d: got %h want %h", c, obs, exp_v);
         end
         if (c < 2) advance();
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (obs !== '0) begin
         miscompares++;
         $display("FAIL test_mid_reset async: got %h want 0", obs);
      end
      model_reset();
      req_valid = '1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive('1, '0, 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_mid_reset after cycle %0d: got %h want %h", c, obs, exp_v);
         end
         if (c == 1) begin
            vectors++;
            if (grant_valid !== 1'b1 || grant_id !== '0) begin
               miscompares++;
               $display("FAIL test_mid_reset first_winner: got valid %b id %0d want valid 1 id 0", grant_valid, grant_id);
            end
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      int writes;
      writes = 0;
      do_reset();
      for (int c = 0; c < 21; c++) begin
         drive(N'(1), '0, 1'b0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_back_to_back cycle %0d: got %h want %h", c, obs, exp_v);
         end
         if (fifo_write) writes++;
         advance();
      end
      vectors++;
      if (writes != 20) begin
         miscompares++;
         $display("FAIL test_back_to_back writes: got %0d want 20", writes);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] v, l;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         v = N'($urandom);
         for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
         drive(v, l, $urandom_range(0, 4) == 0);
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL test_random cycle %0d: got %h want %h", c, obs, exp_v);
         end
         advance();
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_all_valid();
      test_full_hold();
      test_drop_valid();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
